apb_timer: RTL and testbench
============================

// Module: apb_timer
// PURPOSE
// APB3 completer (responder) hosting a 32-bit down-counting timer with interrupt.
// Sits behind the AHB-to-APB bridge on the peripheral bus; answers SETUP/ACCESS
// transfers with optional wait states and PSLVERR on illegal accesses.
// Canonical downstream target for bridge bring-up and regression.
// PARAMETERS
// ADDR_W       12  width of paddr decoded by this block (byte address)
// WAIT_STATES   0  pready-low cycles inserted in every ACCESS phase (0..15)
// PORTS
// clk      in   1       clock
// rst_n    in   1       reset, asynchronous, active-low
// psel     in   1       APB select
// penable  in   1       APB access phase
// pwrite   in   1       1=write, 0=read
// paddr    in   ADDR_W  byte address; only paddr[ADDR_W-1:2] decoded
// pwdata   in   32      write data
// prdata   out  32      read data, valid only when pready=1
// pready   out  1       transfer completes this cycle
// pslverr  out  1       error response, valid only when pready=1
// irq      out  1       INTSTAT.EXP & CTRL.IRQ_EN, level
// BEHAVIOUR
// Register map (word aligned; paddr[1:0] ignored):
//  0x00 CTRL    RW  [0]EN [1]AUTO_RELOAD [2]IRQ_EN, rest RAZ/WI; reset 0
//  0x04 LOAD    RW  32b; write also copies pwdata into VALUE; reset 0
//  0x08 VALUE   RO  current count; write -> pslverr=1, no state change; reset 0
//  0x0C INTSTAT W1C [0]EXP; read returns flag; reset 0
//  >=0x10       unmapped: read -> prdata=0, pslverr=1; write -> pslverr=1, no effect
// APB handshake:
//  - Access cycle = psel&penable. wait_cnt counts 0..WAIT_STATES within access;
//    pready = psel&penable&(wait_cnt==WAIT_STATES); WAIT_STATES=0 -> zero-wait.
//  - Register write commits on the rising edge ending the pready=1 cycle only.
//  - prdata, pslverr driven 0 whenever pready=0; combinational from regs + paddr.
//  - wait_cnt clears when pready=1 or access ends; penable without psel ignored.
//  - Address/control sampled during access; must be stable (bridge guarantees).
// Timer (every cycle, EN=1):
//  - VALUE!=0 -> VALUE-1.
//  - VALUE==0 -> expiry: EXP<=1; AUTO_RELOAD ? VALUE<=LOAD : (VALUE stays 0, EN<=0).
//  - Period with auto-reload = LOAD+1 cycles; LOAD=0 -> expiry every cycle.
//  - EN=0: VALUE frozen.
// Simultaneous events (same cycle):
//  - Expiry vs W1C INTSTAT: set wins, EXP stays 1.
//  - Expiry vs CTRL write: written CTRL wins (incl. EN); EXP still set.
//  - Expiry/decrement vs LOAD write: VALUE<=pwdata.
// Reset: all regs 0, wait_cnt 0; prdata=0, pready=0, pslverr=0, irq=0 while rst_n=0.
// Reset asserted mid-transfer aborts it; no partial write; bus restarts at SETUP.
// STRUCTURE
// apb_pkg: register offset localparams, ctrl_t packed struct (en,auto_reload,irq_en),
//  APB_DATA_W=32. Shared with bridge and other peripherals.
// Sub-module apb_wait_ctrl (WAIT_STATES param): wait_cnt + pready generation;
//  reused by future APB peripherals. Decode, regs, timer live in apb_timer.
// TESTING
// 1 Reset: rst_n low mid-access -> prdata=0,pready=0,pslverr=0,irq=0; all regs read 0.
// 2 WAIT_STATES=2: read LOAD -> pready low 2 access cycles, high 3rd; pslverr=0.
// 3 Write LOAD=5, CTRL=0x7 -> VALUE 5,4..0; EXP+irq 1 on 7th cycle; VALUE reloads 5.
// 4 CTRL=0x1, LOAD=3 -> after expiry VALUE=0, EN reads 0, VALUE frozen.
// 5 Write VALUE or read 0x10 -> pslverr=1 with pready, prdata=0, regs unchanged.
// 6 W1C INTSTAT on expiry cycle (LOAD=0, auto) -> EXP reads 1; W1C later -> 0, irq 0.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB peripheral types and register offsets
package apb_pkg;
   localparam int APB_DATA_W = 32;

   localparam logic [7:0] OFF_CTRL    = 8'h00;
   localparam logic [7:0] OFF_LOAD    = 8'h04;
   localparam logic [7:0] OFF_VALUE   = 8'h08;
   localparam logic [7:0] OFF_INTSTAT = 8'h0C;

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } ctrl_t;
endpackage

// File: rtl/apb_wait_ctrl.sv
// rtl/apb_wait_ctrl.sv - APB access-phase wait-state counter and pready generation
module apb_wait_ctrl #(
   parameter int WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic psel,
   input  logic penable,
   output logic pready
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [3:0] r_wait_cnt;
   logic       w_access;
   logic       w_pready;

   assign w_access = psel & penable;
   // Gated by rst_n so a transfer caught by reset never shows completion
   assign w_pready = rst_n & w_access & (r_wait_cnt == WS);
   assign pready   = w_pready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (!w_access || w_pready) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end
endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB3 completer with a 32-bit down-counting timer and level irq
module apb_timer
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic [APB_DATA_W-1:0] pwdata,
   output logic [APB_DATA_W-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  irq
);
   ctrl_t                 r_ctrl;
   logic [APB_DATA_W-1:0] r_load;
   logic [APB_DATA_W-1:0] r_value;
   logic                  r_exp;

   logic                  w_pready;
   logic [ADDR_W-1:0]     w_addr;
   logic                  w_is_ctrl, w_is_load, w_is_value, w_is_intstat, w_mapped;
   logic                  w_wr;
   logic                  w_expire;
   logic [APB_DATA_W-1:0] w_rdata;

   apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait (
      .clk     (clk),
      .rst_n   (rst_n),
      .psel    (psel),
      .penable (penable),
      .pready  (w_pready)
   );

   assign w_addr       = paddr & ~ADDR_W'(3);
   assign w_is_ctrl    = (w_addr == ADDR_W'(OFF_CTRL));
   assign w_is_load    = (w_addr == ADDR_W'(OFF_LOAD));
   assign w_is_value   = (w_addr == ADDR_W'(OFF_VALUE));
   assign w_is_intstat = (w_addr == ADDR_W'(OFF_INTSTAT));
   assign w_mapped     = w_is_ctrl | w_is_load | w_is_value | w_is_intstat;

   // Only legal writes commit; VALUE and unmapped writes are refused
   assign w_wr     = w_pready & pwrite & w_mapped & ~w_is_value;
   assign w_expire = r_ctrl.en & (r_value == '0);

   always_comb begin
      w_rdata = '0;
      if (w_is_ctrl)    w_rdata = APB_DATA_W'(r_ctrl);
      if (w_is_load)    w_rdata = r_load;
      if (w_is_value)   w_rdata = r_value;
      if (w_is_intstat) w_rdata = APB_DATA_W'(r_exp);
   end

   assign pready  = w_pready;
   assign prdata  = (w_pready & ~pwrite) ? w_rdata : '0;
   assign pslverr = w_pready & (~w_mapped | (pwrite & w_is_value));
   assign irq     = r_exp & r_ctrl.irq_en;

   // Bus writes are placed after the timer update so they take priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl  <= '0;
         r_load  <= '0;
         r_value <= '0;
         r_exp   <= 1'b0;
      end else begin
         if (r_ctrl.en) begin
            if (w_expire) begin
               if (r_ctrl.auto_reload) r_value <= r_load;
               else                    r_ctrl.en <= 1'b0;
            end else begin
               r_value <= r_value - 1'b1;
            end
         end
         r_exp <= (r_exp & ~(w_wr & w_is_intstat & pwdata[0])) | w_expire;
         if (w_wr && w_is_ctrl) r_ctrl <= ctrl_t'(pwdata[2:0]);
         if (w_wr && w_is_load) begin
            r_load  <= pwdata;
            r_value <= pwdata;
         end
      end
   end
endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - directed self-checking bench for apb_timer with two wait states
module tb_apb_timer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        irq;

   int          total = 0;
   int          bad = 0;
   logic [31:0] r_data;
   logic        r_err;
   int          r_nw;

   always #5 clk = ~clk;

   apb_timer #(.ADDR_W(12), .WAIT_STATES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr),
      .irq     (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      r_nw = 0;
      while (!pready && r_nw < 20) begin
         @(posedge clk); #1;
         r_nw++;
      end
      if (!pready) begin
         total++;
         bad++;
         $error("FAIL apb_timeout: got pready=0 want 1 at addr %h", a);
      end
      r_data = prdata;
      r_err  = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic wr_reg(input string tag, input logic [11:0] a, input logic [31:0] d, input logic exp_err);
      apb(1'b1, a, d);
      check({tag, "_err"}, 32'(r_err), 32'(exp_err));
   endtask

   task automatic rd_reg(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic exp_err);
      apb(1'b0, a, 32'h0);
      check(tag, r_data, exp);
      check({tag, "_err"}, 32'(r_err), 32'(exp_err));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // wait states: pready low for two access cycles, high on the third
      rd_reg("ws_load", 12'h004, 32'h0, 1'b0);
      check("ws_count", r_nw, 2);
      psel = 1'b0; penable = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("penable_no_psel", 32'(pready), 32'h0);
      penable = 1'b0;

      // reset in the middle of an INTSTAT read with irq asserted
      wr_reg("rst_load0", 12'h004, 32'h0, 1'b0);
      wr_reg("rst_ctrl7", 12'h000, 32'h7, 1'b0);
      @(posedge clk); #1;
      check("rst_irq_pre", 32'(irq), 32'h1);
      @(posedge clk); #1;
      psel = 1'b1; pwrite = 1'b0; paddr = 12'h00C;
      @(posedge clk); #1 penable = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("rst_pready_pre", 32'(pready), 32'h1);
      check("rst_prdata_pre", prdata, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_prdata", prdata, 32'h0);
      check("rst_pready", 32'(pready), 32'h0);
      check("rst_pslverr", 32'(pslverr), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      rd_reg("rst_ctrl", 12'h000, 32'h0, 1'b0);
      rd_reg("rst_load", 12'h004, 32'h0, 1'b0);
      rd_reg("rst_value", 12'h008, 32'h0, 1'b0);
      rd_reg("rst_intstat", 12'h00C, 32'h0, 1'b0);

      // auto-reload, LOAD=5: expiry on the sixth edge after the CTRL write
      wr_reg("t3_load", 12'h004, 32'h5, 1'b0);
      rd_reg("t3_value_ld", 12'h008, 32'h5, 1'b0);
      wr_reg("t3_ctrl", 12'h000, 32'h7, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check($sformatf("t3_irq_c%0d", k), 32'(irq), (k == 6) ? 32'h1 : 32'h0);
      end
      rd_reg("t3_value_run", 12'h008, 32'h1, 1'b0);
      rd_reg("t3_intstat", 12'h00C, 32'h1, 1'b0);
      wr_reg("t3_stop", 12'h000, 32'h0, 1'b0);
      rd_reg("t3_value_frz", 12'h008, 32'h2, 1'b0);
      rd_reg("t3_value_frz2", 12'h008, 32'h2, 1'b0);
      wr_reg("t3_w1c", 12'h00C, 32'h1, 1'b0);
      rd_reg("t3_intstat_clr", 12'h00C, 32'h0, 1'b0);

      // one-shot, LOAD=3: EN drops at expiry and VALUE stays 0
      wr_reg("t4_load", 12'h004, 32'h3, 1'b0);
      wr_reg("t4_ctrl", 12'h000, 32'h1, 1'b0);
      rd_reg("t4_ctrl_rd", 12'h000, 32'h0, 1'b0);
      rd_reg("t4_value", 12'h008, 32'h0, 1'b0);
      rd_reg("t4_value2", 12'h008, 32'h0, 1'b0);
      rd_reg("t4_intstat", 12'h00C, 32'h1, 1'b0);
      check("t4_irq_masked", 32'(irq), 32'h0);
      wr_reg("t4_w1c", 12'h00C, 32'h1, 1'b0);

      // error responses and RAZ/WI bits
      wr_reg("t5_wr_value", 12'h008, 32'h1234, 1'b1);
      rd_reg("t5_value", 12'h008, 32'h0, 1'b0);
      rd_reg("t5_unmapped", 12'h010, 32'h0, 1'b1);
      rd_reg("t5_unmapped_top", 12'hFFC, 32'h0, 1'b1);
      wr_reg("t5_wr_unmapped", 12'h010, 32'hFF, 1'b1);
      rd_reg("t5_load_byteaddr", 12'h007, 32'h3, 1'b0);
      wr_reg("t5_ctrl_raz", 12'h000, 32'hFFFF_FFFC, 1'b0);
      rd_reg("t5_ctrl_rd", 12'h000, 32'h4, 1'b0);

      // LOAD=0 auto-reload: W1C collides with expiry and loses
      wr_reg("t6_load", 12'h004, 32'h0, 1'b0);
      wr_reg("t6_ctrl", 12'h000, 32'h7, 1'b0);
      wr_reg("t6_w1c_hit", 12'h00C, 32'h1, 1'b0);
      rd_reg("t6_intstat_set", 12'h00C, 32'h1, 1'b0);
      check("t6_irq_on", 32'(irq), 32'h1);
      wr_reg("t6_ctrl_stop", 12'h000, 32'h4, 1'b0);
      check("t6_irq_held", 32'(irq), 32'h1);
      wr_reg("t6_w1c", 12'h00C, 32'h1, 1'b0);
      rd_reg("t6_intstat_clr", 12'h00C, 32'h0, 1'b0);
      check("t6_irq_off", 32'(irq), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
